i2c_txn_arbiter: RTL and testbench
==================================

Name: i2c_txn_arbiter

Overview:
- Shares one I2C master byte engine among NREQ requesters; each requester presents a single-byte transaction (7-bit slave address, R/W, write byte).
- Round-robin arbitration, launches the engine, waits for completion and returns read data / NACK status to the winner.
- Sits between the system-side clients and the SCL/SDA master engine; optional watchdog aborts hung transfers.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADDR_W, 7, I2C slave address width.
- TIMEOUT_CYC, 1024, cycles in WAIT before abort (used only with I2C_TIMEOUT_EN).

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous, active-low reset.
- req  in  NREQ  per-requester transaction request (level).
- req_addr  in  NREQ*ADDR_W  flattened slave addresses, requester i at [i*ADDR_W +: ADDR_W].
- req_rw  in  NREQ  1 = read, 0 = write.
- req_wdata  in  NREQ*8  flattened write bytes.
- gnt  out  NREQ  one-hot grant, held for the whole transaction.
- done  out  NREQ  one-hot, one-cycle completion pulse.
- rdata  out  8  read byte, valid with done.
- nack  out  1  slave NACK or abort, valid with done.
- timeout  out  1  one-cycle pulse on watchdog abort.
- eng_start  out  1  one-cycle launch pulse to the engine.
- eng_addr  out  ADDR_W  latched address.
- eng_rw  out  1  latched direction.
- eng_wdata  out  8  latched write byte.
- eng_abort  out  1  one-cycle abort pulse (watchdog only).
- eng_busy  in  1  engine busy.
- eng_done  in  1  engine completion pulse.
- eng_rdata  in  8  engine read byte.
- eng_nack  in  1  engine NACK flag.

Behaviour:
- All outputs are registered.
- Reset (sys_rst == 0 at a clock edge, any state):
  - state = IDLE.
  - gnt, done, rdata, nack, timeout, eng_start, eng_abort, eng_addr, eng_rw, eng_wdata all = 0.
  - RR pointer last = NREQ-1, so requester 0 has top priority first.
  - Reset mid-transaction does not pulse eng_abort.
- States:
  - IDLE: if |req and !eng_busy, pick the winner as the first asserted req scanning last+1, last+2, … modulo NREQ. Latch idx, req_addr/rw/wdata of idx into eng_*. Set gnt[idx] = 1. Go LAUNCH. If eng_busy, hold in IDLE with no grant.
  - LAUNCH: eng_start = 1 for exactly this cycle. Go WAIT.
  - WAIT: on eng_done, capture rdata = eng_rdata and nack = eng_nack, set done[idx] = 1, clear gnt. Go RESP.
  - RESP: one cycle with done[idx] high. Then clear done, set last = idx, go IDLE.
- Latency (engine idle):
  - req sampled at edge k → gnt high after edge k.
  - eng_start high between edges k+1 and k+2.
  - eng_done sampled at edge m → done/rdata/nack high for the cycle after edge m.
  - Minimum turnaround from done to next grant: 1 cycle (RESP → IDLE → grant at the next edge).
- Requester rules:
  - req_* fields must be stable from req assertion until gnt.
  - Dropping req after grant does not cancel the transaction.
  - A requester must drop req the cycle it sees done, or it re-enters arbitration at lowest priority.
- eng_done outside WAIT is ignored.
- Simultaneous requests are resolved purely by RR order, never by index.
- rdata/nack hold their values until the next completion.
- Width rule: idx and last are $clog2(NREQ) bits (minimum 1); pointer increment wraps modulo NREQ, including non-power-of-two NREQ.

Optional Feature:
- Macro: I2C_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When count reaches TIMEOUT_CYC-1 without eng_done: eng_abort = 1 and timeout = 1 for one cycle, nack = 1, rdata = 0, done[idx] pulses, then RESP → IDLE as normal.
  - eng_done in the same cycle as expiry wins (normal completion, no timeout).
- Not defined:
  - WAIT is unbounded.
  - timeout and eng_abort are tied to 0.
  - No counter logic is synthesised.

Test Plan:
- Reset: sys_rst = 0 for 3 cycles with req = 4'b1111 → all outputs 0; after release, first gnt = 4'b0001.
- Single write: req[2] with addr 7'h65, rw 0, wdata 8'hA5; engine done 10 cycles after start with nack 0 → gnt = 4'b0100 one cycle after req, eng_start one cycle later with eng_addr = 7'h65 and eng_wdata = 8'hA5, done = 4'b0100 pulse, nack = 0.
- Round robin: req = 4'b1111 held, each requester drops req on its done → grant order 0, 1, 2, 3, 0.
- Read with NACK: req[1] read, engine returns eng_rdata = 8'h3C, eng_nack = 1 → rdata = 8'h3C, nack = 1, done = 4'b0010 pulse.
- Busy/reset: eng_busy = 1 with req[0] → no gnt until eng_busy = 0. Separately, assert reset during WAIT → state IDLE, gnt = 0, no done pulse.
- Timeout (I2C_TIMEOUT_EN, TIMEOUT_CYC = 16): engine never pulses done → 16 WAIT cycles later eng_abort = timeout = 1, done[idx] pulse, nack = 1, rdata = 0. Without the macro, gnt holds indefinitely.

Source files
------------

// File: rtl/i2c_txn_arbiter_if.sv
// i2c_txn_arbiter_if: requester-side and engine-side signals of the I2C
// transaction arbiter. The master modport is the arbiter's view; the slave
// modport is the view of the surrounding clients and byte engine.
interface i2c_txn_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 7
);
    // requester side
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]        req_rw;
    logic [NREQ*8-1:0]      req_wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic [7:0]             rdata;
    logic                   nack;
    logic                   timeout;
    // engine side
    logic                   eng_start;
    logic [ADDR_W-1:0]      eng_addr;
    logic                   eng_rw;
    logic [7:0]             eng_wdata;
    logic                   eng_abort;
    logic                   eng_busy;
    logic                   eng_done;
    logic [7:0]             eng_rdata;
    logic                   eng_nack;

    modport master (
        input  req, req_addr, req_rw, req_wdata,
        input  eng_busy, eng_done, eng_rdata, eng_nack,
        output gnt, done, rdata, nack, timeout,
        output eng_start, eng_addr, eng_rw, eng_wdata, eng_abort
    );

    modport slave (
        output req, req_addr, req_rw, req_wdata,
        output eng_busy, eng_done, eng_rdata, eng_nack,
        input  gnt, done, rdata, nack, timeout,
        input  eng_start, eng_addr, eng_rw, eng_wdata, eng_abort
    );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin sharing of one I2C byte engine among NREQ
// requesters. Flow per transaction: IDLE (arbitrate) -> LAUNCH (start pulse)
// -> WAIT (engine running) -> RESP (done pulse) -> IDLE.
// Optional macro I2C_TIMEOUT_EN adds a WAIT watchdog that aborts the engine
// after TIMEOUT_CYC cycles; without it WAIT is unbounded and timeout/eng_abort
// stay low.
module i2c_txn_arbiter #(
    parameter int NREQ        = 4,
    parameter int ADDR_W      = 7,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    i2c_txn_arbiter_if.master bus
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [NREQ-1:0]  ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NREQ - 1);

`ifdef I2C_TIMEOUT_EN
    localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT_CYC - 1);
    logic [15:0] cnt_r;
`endif

    logic [1:0]        state_r;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  last_r;
    logic [NREQ-1:0]   gnt_r;
    logic [NREQ-1:0]   done_r;
    logic [7:0]        rdata_r;
    logic              nack_r;
    logic              timeout_r;
    logic              eng_start_r;
    logic [ADDR_W-1:0] eng_addr_r;
    logic              eng_rw_r;
    logic [7:0]        eng_wdata_r;
    logic              eng_abort_r;

    logic              win_found_s;
    logic [IDX_W-1:0]  win_idx_s;
    logic [IDX_W-1:0]  cand_s;

    // Round-robin pick: first asserted request scanning last+1, last+2, ... mod NREQ
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = IDX_W'((int'(last_r) + k) % NREQ);
            if (!win_found_s && bus.req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Arbitration FSM, latched transaction fields and all registered outputs
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            last_r      <= LAST_INIT;
            gnt_r       <= '0;
            done_r      <= '0;
            rdata_r     <= 8'h00;
            nack_r      <= 1'b0;
            timeout_r   <= 1'b0;
            eng_start_r <= 1'b0;
            eng_addr_r  <= '0;
            eng_rw_r    <= 1'b0;
            eng_wdata_r <= 8'h00;
            eng_abort_r <= 1'b0;
`ifdef I2C_TIMEOUT_EN
            cnt_r       <= 16'd0;
`endif
        end else begin
            // pulses default low; each state raises its own for one cycle
            done_r      <= '0;
            eng_start_r <= 1'b0;
            timeout_r   <= 1'b0;
            eng_abort_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s && !bus.eng_busy) begin
                        idx_r       <= win_idx_s;
                        gnt_r       <= ONE_HOT0 << win_idx_s;
                        eng_addr_r  <= bus.req_addr[int'(win_idx_s) * ADDR_W +: ADDR_W];
                        eng_rw_r    <= bus.req_rw[win_idx_s];
                        eng_wdata_r <= bus.req_wdata[int'(win_idx_s) * 8 +: 8];
                        state_r     <= ST_LAUNCH;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    eng_start_r <= 1'b1;
                    state_r     <= ST_WAIT;
`ifdef I2C_TIMEOUT_EN
                    cnt_r       <= 16'd0;
`endif
                end
                ST_WAIT: begin
                    // a completion in the expiry cycle takes precedence over the abort
                    if (bus.eng_done) begin
                        rdata_r <= bus.eng_rdata;
                        nack_r  <= bus.eng_nack;
                        done_r  <= ONE_HOT0 << idx_r;
                        gnt_r   <= '0;
                        state_r <= ST_RESP;
                    end
`ifdef I2C_TIMEOUT_EN
                    else if (cnt_r == CNT_LIMIT) begin
                        rdata_r     <= 8'h00;
                        nack_r      <= 1'b1;
                        done_r      <= ONE_HOT0 << idx_r;
                        gnt_r       <= '0;
                        timeout_r   <= 1'b1;
                        eng_abort_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
                        cnt_r   <= cnt_r + 16'd1;
                        state_r <= ST_WAIT;
                    end
`else
                    else begin
                        state_r <= ST_WAIT;
                    end
`endif
                end
                ST_RESP: begin
                    last_r  <= idx_r;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.done      = done_r;
    assign bus.rdata     = rdata_r;
    assign bus.nack      = nack_r;
    assign bus.timeout   = timeout_r;
    assign bus.eng_start = eng_start_r;
    assign bus.eng_addr  = eng_addr_r;
    assign bus.eng_rw    = eng_rw_r;
    assign bus.eng_wdata = eng_wdata_r;
    assign bus.eng_abort = eng_abort_r;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb_i2c_txn_arbiter: transaction-level randomized bench. A reference model
// keeps the pending request set, the round-robin pointer and the last
// completion data; each transaction's grant, launch fields, latency and
// completion are checked against it. Define I2C_TIMEOUT_EN to also build
// the watchdog expectations.
module tb_i2c_txn_arbiter;

    localparam int NREQ        = 4;
    localparam int ADDR_W      = 7;
    localparam int TIMEOUT_CYC = 16;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;

    i2c_txn_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W)) bus ();

    i2c_txn_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    // reference model state
    logic [NREQ-1:0]   pending;
    logic [ADDR_W-1:0] addr_m [NREQ];
    logic              rw_m   [NREQ];
    logic [7:0]        wd_m   [NREQ];
    int                last_m;
    logic [7:0]        rdata_m;
    logic              nack_m;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int w);
        logic [NREQ-1:0] v;
        v = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    // winner = first pending requester after the last served one, wrapping
    function automatic int pick_winner(input logic [NREQ-1:0] p, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (p[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_fields(input int i);
        addr_m[i] = ADDR_W'($urandom);
        rw_m[i]   = 1'($urandom_range(0, 1));
        wd_m[i]   = 8'($urandom);
    endtask

    task automatic add_random_reqs();
        for (int i = 0; i < NREQ; i++) begin
            if (!pending[i] && $urandom_range(0, 2) == 0) begin
                set_fields(i);
                pending[i] = 1'b1;
            end
        end
        if (pending == '0) begin
            int j;
            j = $urandom_range(0, NREQ - 1);
            set_fields(j);
            pending[j] = 1'b1;
        end
    endtask

    task automatic apply_req();
        for (int i = 0; i < NREQ; i++) begin
            bus.req[i]                          = pending[i];
            bus.req_addr[i*ADDR_W +: ADDR_W]    = addr_m[i];
            bus.req_rw[i]                       = rw_m[i];
            bus.req_wdata[i*8 +: 8]             = wd_m[i];
        end
    endtask

    // One full transaction, starting at a negedge with the DUT in IDLE
    // (extra = 0) or in RESP (extra = 1). busy_n: IDLE cycles with eng_busy
    // high; lat: negedges after the launch before the engine reports done.
    task automatic do_txn(input int busy_n, input int extra, input int lat,
                          input logic [7:0] e_rd, input logic e_nk);
        int   w, n, waits;
        bit   got, to;
        logic [7:0] exp_rd;
        logic       exp_nk;
        apply_req();
        w = pick_winner(pending, last_m);
        if (w < 0) return;
        bus.eng_busy = (busy_n > 0);
        n   = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(negedge sys_clk);
            n++;
            bus.eng_done = 1'b0;
            if (bus.gnt != '0) begin
                got = 1'b1;
            end else begin
                check_val("no_done_idle", 32'(bus.done), 32'd0);
                if (n >= extra + busy_n) bus.eng_busy = 1'b0;
                bus.eng_done = ($urandom_range(0, 3) == 0);
            end
        end
        bus.eng_done = 1'b0;
        bus.eng_busy = 1'b0;
        check_val("gnt_latency", 32'(n), 32'(extra + busy_n + 1));
        check_val("gnt", 32'(bus.gnt), 32'(onehot(w)));
        check_val("rdata_hold", 32'(bus.rdata), 32'(rdata_m));
        check_val("nack_hold", 32'(bus.nack), 32'(nack_m));
        if (!got) return;
        // dropping req after the grant must not cancel the transaction
        if ($urandom_range(0, 1) == 1) begin
            pending[w] = 1'b0;
            apply_req();
        end
        @(negedge sys_clk);
        check_val("eng_start", 32'(bus.eng_start), 32'd1);
        check_val("eng_addr", 32'(bus.eng_addr), 32'(addr_m[w]));
        check_val("eng_rw", 32'(bus.eng_rw), 32'(rw_m[w]));
        check_val("eng_wdata", 32'(bus.eng_wdata), 32'(wd_m[w]));
        check_val("gnt_launch", 32'(bus.gnt), 32'(onehot(w)));
`ifdef I2C_TIMEOUT_EN
        to = (lat >= TIMEOUT_CYC);
`else
        to = 1'b0;
`endif
        waits = to ? (TIMEOUT_CYC - 1) : lat;
        for (int c = 0; c < waits; c++) begin
            @(negedge sys_clk);
            check_val("gnt_wait", 32'(bus.gnt), 32'(onehot(w)));
            check_val("done_wait", 32'(bus.done), 32'd0);
            check_val("start_once", 32'(bus.eng_start), 32'd0);
        end
        if (!to) begin
            bus.eng_done  = 1'b1;
            bus.eng_rdata = e_rd;
            bus.eng_nack  = e_nk;
        end
        @(negedge sys_clk);
        bus.eng_done  = 1'b0;
        bus.eng_rdata = 8'($urandom);
        bus.eng_nack  = 1'($urandom_range(0, 1));
        exp_rd = to ? 8'h00 : e_rd;
        exp_nk = to ? 1'b1 : e_nk;
        check_val("done", 32'(bus.done), 32'(onehot(w)));
        check_val("rdata", 32'(bus.rdata), 32'(exp_rd));
        check_val("nack", 32'(bus.nack), 32'(exp_nk));
        check_val("timeout", 32'(bus.timeout), 32'(to));
        check_val("eng_abort", 32'(bus.eng_abort), 32'(to));
        check_val("gnt_clear", 32'(bus.gnt), 32'd0);
        rdata_m    = exp_rd;
        nack_m     = exp_nk;
        last_m     = w;
        pending[w] = 1'b0;
        apply_req();
    endtask

    initial begin
        int n;
        bus.req       = '0;
        bus.req_addr  = '0;
        bus.req_rw    = '0;
        bus.req_wdata = '0;
        bus.eng_busy  = 1'b0;
        bus.eng_done  = 1'b0;
        bus.eng_rdata = 8'h00;
        bus.eng_nack  = 1'b0;

        // reset with every requester asking
        sys_rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_fields(i);
        pending = '1;
        apply_req();
        repeat (3) @(negedge sys_clk);
        check_val("rst_gnt", 32'(bus.gnt), 32'd0);
        check_val("rst_done", 32'(bus.done), 32'd0);
        check_val("rst_rdata", 32'(bus.rdata), 32'd0);
        check_val("rst_nack", 32'(bus.nack), 32'd0);
        check_val("rst_timeout", 32'(bus.timeout), 32'd0);
        check_val("rst_start", 32'(bus.eng_start), 32'd0);
        check_val("rst_abort", 32'(bus.eng_abort), 32'd0);
        check_val("rst_addr", 32'(bus.eng_addr), 32'd0);
        check_val("rst_rw", 32'(bus.eng_rw), 32'd0);
        check_val("rst_wdata", 32'(bus.eng_wdata), 32'd0);
        last_m  = NREQ - 1;
        rdata_m = 8'h00;
        nack_m  = 1'b0;
        sys_rst = 1'b1;

        // round robin with all requesters held: 0,1,2,3 then 0 again
        for (int t = 0; t < NREQ; t++) begin
            do_txn(0, (t == 0) ? 0 : 1, $urandom_range(0, 6), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        pending[0] = 1'b1;
        do_txn(0, 1, 2, 8'h11, 1'b0);

        // single write from requester 2
        pending = '0;
        pending[2] = 1'b1;
        addr_m[2] = 7'h65;
        rw_m[2]   = 1'b0;
        wd_m[2]   = 8'hA5;
        do_txn(0, 1, 10, 8'h00, 1'b0);

        // read with NACK from requester 1
        pending = '0;
        pending[1] = 1'b1;
        set_fields(1);
        rw_m[1] = 1'b1;
        do_txn(0, 1, 5, 8'h3C, 1'b1);

        // engine busy holds off the grant
        pending = '0;
        pending[0] = 1'b1;
        set_fields(0);
        do_txn(4, 1, 3, 8'h5A, 1'b0);

        // watchdog boundaries and a long hang
        add_random_reqs();
        do_txn(0, 1, TIMEOUT_CYC - 1, 8'h77, 1'b0);
        add_random_reqs();
        do_txn(0, 1, TIMEOUT_CYC, 8'h88, 1'b0);
        add_random_reqs();
        do_txn(0, 1, 40, 8'h99, 1'b1);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            add_random_reqs();
            do_txn(($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0, 1,
                   $urandom_range(0, 20), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        // reset in the middle of WAIT
        add_random_reqs();
        apply_req();
        n = 0;
        while (bus.gnt == '0 && n < 10) begin
            @(negedge sys_clk);
            n++;
        end
        check_val("pre_rst_gnt", 32'(bus.gnt != '0), 32'd1);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check_val("mid_rst_gnt", 32'(bus.gnt), 32'd0);
        check_val("mid_rst_done", 32'(bus.done), 32'd0);
        check_val("mid_rst_abort", 32'(bus.eng_abort), 32'd0);
        check_val("mid_rst_timeout", 32'(bus.timeout), 32'd0);
        check_val("mid_rst_rdata", 32'(bus.rdata), 32'd0);
        check_val("mid_rst_nack", 32'(bus.nack), 32'd0);
        sys_rst = 1'b1;
        last_m  = NREQ - 1;
        rdata_m = 8'h00;
        nack_m  = 1'b0;
        do_txn(0, 0, $urandom_range(0, 8), 8'($urandom), 1'($urandom_range(0, 1)));
        for (int t = 0; t < 10; t++) begin
            add_random_reqs();
            do_txn($urandom_range(0, 2), 1, $urandom_range(0, 20), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
